// File: rtl/scroll_ctrl.sv
// Per-frame viewport scroll sequencer: moves the screen window on each frame edge, then
// looks up the platform segment under the player. Define SCROLL_STATS_EN for frame_drop_cnt.
module scroll_ctrl #(
  parameter logic [13:0] MAP_LEN  = 14'd4473,
  parameter logic [13:0] SCREEN_W = 14'd639,
  parameter logic [13:0] SPEED    = 14'd10,
  parameter int          NUM_SEG  = 3,
  parameter logic [13:0] TOP_RST  = 14'd300,
  parameter logic [13:0] BOT_RST  = 14'd350,
  localparam int         AW       = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_clk,
  input  logic [7:0]    keycode,
  input  logic [13:0]   player_location,
  output logic [AW-1:0] seg_addr,
  input  logic [13:0]   seg_x,
  input  logic [13:0]   seg_top,
  input  logic [13:0]   seg_bot,
  output logic [13:0]   left_bound,
  output logic [13:0]   right_bound,
  output logic          can_move,
  output logic [13:0]   top,
  output logic [13:0]   bot,
  output logic          upd_valid,
  output logic          busy
`ifdef SCROLL_STATS_EN
  ,output logic [7:0]   frame_drop_cnt
`endif
);

  localparam int            CW       = $clog2(NUM_SEG + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_SEG);
  localparam logic [7:0]    KEY_A    = 8'h04;
  localparam logic [7:0]    KEY_D    = 8'h07;

  typedef enum logic [1:0] {IDLE, SCROLL, SEARCH, COMMIT} state_t;

  state_t        state, state_nx;
  logic          frame_clk_d, fe;
  logic [7:0]    key_q;
  logic [13:0]   loc_q;
  logic [13:0]   sh_left, sh_right, sh_top, sh_bot;
  logic          sh_can_move;
  logic [CW-1:0] addr_cnt;
  logic          cmp_vld;
  logic          latch_en, commit_en, cmp_en, search_done, key_move;

  // Registered rising-edge detect turns the slow frame clock into a one-cycle pulse.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      frame_clk_d <= 1'b0;
      fe          <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      frame_clk_d <= frame_clk;
      fe          <= frame_clk & ~frame_clk_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      IDLE:    if (fe) state_nx = SCROLL;
      SCROLL:  state_nx = key_move ? SEARCH : COMMIT;
      SEARCH:  if (search_done) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    latch_en    = (state == IDLE) && fe;
    commit_en   = (state == COMMIT);
    key_move    = (key_q == KEY_A) || (key_q == KEY_D);
    cmp_en      = (state == SEARCH) && cmp_vld;
    search_done = cmp_en && ((seg_x > loc_q) || (addr_cnt == LAST_CNT));
    seg_addr    = (addr_cnt >= LAST_CNT) ? AW'(NUM_SEG - 1) : AW'(addr_cnt);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      key_q       <= '0;
      loc_q       <= '0;
      sh_left     <= '0;
      sh_right    <= SCREEN_W;
      sh_top      <= TOP_RST;
      sh_bot      <= BOT_RST;
      sh_can_move <= 1'b1;
      addr_cnt    <= '0;
      cmp_vld     <= 1'b0;
      left_bound  <= '0;
      right_bound <= SCREEN_W;
      top         <= TOP_RST;
      bot         <= BOT_RST;
      can_move    <= 1'b1;
      upd_valid   <= 1'b0;
    end else begin
      if (latch_en) begin
        key_q  <= keycode;
        loc_q  <= player_location;
        sh_top <= top;
        sh_bot <= bot;
      end

      if (state == SCROLL) begin
        if (key_q == KEY_A) begin
          if (left_bound <= SPEED) begin
            sh_left     <= '0;
            sh_right    <= SCREEN_W;
            sh_can_move <= 1'b1;
          end else begin
            sh_left     <= left_bound - SPEED;
            sh_right    <= right_bound - SPEED;
            sh_can_move <= 1'b0;
          end
        end else if (key_q == KEY_D) begin
          if ((right_bound + SPEED) >= MAP_LEN) begin
            sh_left     <= MAP_LEN - SCREEN_W;
            sh_right    <= MAP_LEN;
            sh_can_move <= 1'b1;
          end else begin
            sh_left     <= left_bound + SPEED;
            sh_right    <= right_bound + SPEED;
            sh_can_move <= 1'b0;
          end
        end else begin
          sh_left     <= left_bound;
          sh_right    <= right_bound;
          sh_can_move <= 1'b0;
        end
      end

      // Table has one cycle of read latency: address k goes out, entry k is compared next cycle.
      if (state == SEARCH) begin
        if (addr_cnt != LAST_CNT) begin
          addr_cnt <= addr_cnt + 1'b1;
          cmp_vld  <= 1'b1;
        end
        if (cmp_en && (seg_x <= loc_q)) begin
          sh_top <= seg_top;
          sh_bot <= seg_bot;
        end
      end else begin
        addr_cnt <= '0;
        cmp_vld  <= 1'b0;
      end

      if (commit_en) begin
        left_bound  <= sh_left;
        right_bound <= sh_right;
        top         <= sh_top;
        bot         <= sh_bot;
        can_move    <= sh_can_move;
      end
      upd_valid <= commit_en;
    end
  end

`ifdef SCROLL_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n)                              frame_drop_cnt <= '0;
    else if (fe && busy && frame_drop_cnt != 8'hFF) frame_drop_cnt <= frame_drop_cnt + 8'd1;
  end
`endif

endmodule
